stopwatch_controller: RTL and testbench

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_pkg.sv | 33 +++
 rtl/stopwatch_controller_if.sv | 24 ++
 rtl/bcd_time_step.sv | 65 ++++++
 rtl/stopwatch_controller.sv | 125 ++++++++++++
 tb/tb_stopwatch_controller.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM states,
// BCD digit and time formats, and the limit helpers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
    } time_t;

    localparam int SEC_MAX = 59;
    localparam int ADJ_MIN = 2;

    function automatic int bcd2_to_int(input bcd_t hi, input bcd_t lo);
        return 10 * int'(hi) + int'(lo);
    endfunction

    // Upper time limit MAX_MIN:59 as a BCD time value.
    function automatic time_t max_time(input int max_min);
        return {bcd_t'(max_min / 10), bcd_t'(max_min % 10),
                bcd_t'(SEC_MAX / 10), bcd_t'(SEC_MAX % 10)};
    endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// Control/status bundle between the stopwatch controller and its user.
interface stopwatch_controller_if;

    logic        START_STOP;
    logic        CLR;
    logic        ADD2;
    logic        SUB2;
    logic        MODE;
    logic [15:0] TIME;
    logic        RUNNING;
    logic        DONE;
    logic        REJECT;

    modport master (
        output START_STOP, CLR, ADD2, SUB2, MODE,
        input  TIME, RUNNING, DONE, REJECT
    );

    modport slave (
        input  START_STOP, CLR, ADD2, SUB2, MODE,
        output TIME, RUNNING, DONE, REJECT
    );

endinterface

// File: rtl/bcd_time_step.sv
// Combinational one-second BCD step (up or down) with a flag that is set
// when the result sits on the count limit for that direction.
module bcd_time_step
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  time_t cur,
    input  logic  down,
    output time_t nxt,
    output logic  limit
);

    localparam time_t MAX_TIME = max_time(MAX_MIN);

    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        nxt   = cur;
        limit = 1'b0;
        if (!down) begin
            // Saturate at the limit so an adjusted-into-limit RUN never overflows.
            if (cur != MAX_TIME) begin
                if (cur.s0 != 4'd9) begin
                    nxt.s0 = cur.s0 + 4'd1;
                end else begin
                    nxt.s0 = 4'd0;
                    if (cur.s1 != 4'd5) begin
                        nxt.s1 = cur.s1 + 4'd1;
                    end else begin
                        nxt.s1 = 4'd0;
                        if (cur.m0 != 4'd9) begin
                            nxt.m0 = cur.m0 + 4'd1;
                        end else begin
                            nxt.m0 = 4'd0;
                            nxt.m1 = cur.m1 + 4'd1;
                        end
                    end
                end
            end
            limit = (nxt == MAX_TIME);
        end else begin
            if (cur != '0) begin
                if (cur.s0 != 4'd0) begin
                    nxt.s0 = cur.s0 - 4'd1;
                end else begin
                    nxt.s0 = 4'd9;
                    if (cur.s1 != 4'd0) begin
                        nxt.s1 = cur.s1 - 4'd1;
                    end else begin
                        nxt.s1 = 4'd5;
                        if (cur.m0 != 4'd0) begin
                            nxt.m0 = cur.m0 - 4'd1;
                        end else begin
                            nxt.m0 = 4'd9;
                            nxt.m1 = cur.m1 - 4'd1;
                        end
                    end
                end
            end
            limit = (nxt == '0);
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch FSM (IDLE/RUN/DONE) with a one-second prescaler, BCD up/down
// counting and +/-2 minute adjustments.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 50000000,
    parameter int MAX_MIN = 59
) (
    input  logic                         CLK,
    input  logic                         RST,
    stopwatch_controller_if.slave        bus
);

    localparam int    PW       = $clog2(CLK_DIV);
    localparam time_t MAX_TIME = max_time(MAX_MIN);

    state_e        state_q, state_d;
    time_t         time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          reject_q, reject_d;

    time_t step_nxt;
    logic  step_limit;

    bcd_time_step #(.MAX_MIN(MAX_MIN)) u_step (
        .cur   (time_q),
        .down  (bus.MODE),
        .nxt   (step_nxt),
        .limit (step_limit)
    );

    int    mins;
    logic  tick, adj_req, add_ok, sub_ok, adj_ok, start_blocked;
    time_t time_add, time_sub;

    always_comb begin
        mins    = bcd2_to_int(time_q.m1, time_q.m0);
        tick    = (state_q == RUN) && (presc_q == PW'(CLK_DIV - 1));
        adj_req = bus.ADD2 | bus.SUB2;
        add_ok  = (mins + ADJ_MIN) <= MAX_MIN;
        sub_ok  = mins >= ADJ_MIN;
        adj_ok  = (bus.ADD2 && !bus.SUB2 && add_ok) || (bus.SUB2 && !bus.ADD2 && sub_ok);
        start_blocked = (!bus.MODE && time_q == MAX_TIME) || (bus.MODE && time_q == '0);

        // Minutes +/-2 in BCD; seconds untouched.
        time_add = time_q;
        time_sub = time_q;
        if (time_q.m0 >= 4'd8) begin
            time_add.m0 = time_q.m0 - 4'd8;
            time_add.m1 = time_q.m1 + 4'd1;
        end else begin
            time_add.m0 = time_q.m0 + 4'd2;
        end
        if (time_q.m0 >= 4'd2) begin
            time_sub.m0 = time_q.m0 - 4'd2;
        end else begin
            time_sub.m0 = time_q.m0 + 4'd8;
            time_sub.m1 = time_q.m1 - 4'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        presc_d  = presc_q;
        reject_d = adj_req && !adj_ok;

        if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        // Priority: CLR > adjustment > START_STOP > tick; lower events are dropped.
        if (bus.CLR) begin
            time_d  = '0;
            state_d = IDLE;
            presc_d = '0;
        end else if (adj_req) begin
            if (adj_ok) begin
                time_d = bus.ADD2 ? time_add : time_sub;
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        end else if (bus.START_STOP) begin
            unique case (state_q)
                IDLE: begin
                    if (!start_blocked) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN:     state_d = IDLE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (tick) begin
            time_d = step_nxt;
            if (step_limit) begin
                state_d = DONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            time_q   <= '0;
            presc_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            presc_q  <= presc_d;
            reject_q <= reject_d;
        end
    end

    assign bus.TIME    = time_q;
    assign bus.RUNNING = (state_q == RUN);
    assign bus.DONE    = (state_q == DONE);
    assign bus.REJECT  = reject_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with CLK_DIV=4, MAX_MIN=59.
module tb_stopwatch_controller;

    logic CLK;
    logic RST;
    int   tests_run;
    int   tests_failed;

    stopwatch_controller_if bus ();

    stopwatch_controller #(.CLK_DIV(4), .MAX_MIN(59)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drives the given pulses for one clock; returns at the following negedge.
    task automatic do_pulse(input logic ss, input logic clr, input logic add, input logic sub);
        bus.START_STOP = ss;
        bus.CLR        = clr;
        bus.ADD2       = add;
        bus.SUB2       = sub;
        @(negedge CLK);
        bus.START_STOP = 1'b0;
        bus.CLR        = 1'b0;
        bus.ADD2       = 1'b0;
        bus.SUB2       = 1'b0;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        RST            = 1'b0;
        bus.START_STOP = 1'b0;
        bus.CLR        = 1'b0;
        bus.ADD2       = 1'b0;
        bus.SUB2       = 1'b0;
        bus.MODE       = 1'b0;
        wait_cycles(2);
        check("rst_time", bus.TIME, 16'h0000);
        check("rst_running", 16'(bus.RUNNING), 16'h0);
        check("rst_done", 16'(bus.DONE), 16'h0);
        check("rst_reject", 16'(bus.REJECT), 16'h0);

        // Up count from reset; first event accepted in the first RST=1 cycle.
        RST = 1'b1;
        do_pulse(1, 0, 0, 0);
        check("up_start_running", 16'(bus.RUNNING), 16'h1);
        wait_cycles(3);
        check("up_pre_tick", bus.TIME, 16'h0000);
        wait_cycles(1);
        check("up_tick1", bus.TIME, 16'h0001);
        wait_cycles(4);
        check("up_tick2", bus.TIME, 16'h0002);
        wait_cycles(4);
        check("up_tick3", bus.TIME, 16'h0003);
        check("up_running", 16'(bus.RUNNING), 16'h1);
        do_pulse(1, 0, 0, 0);
        check("stop_running", 16'(bus.RUNNING), 16'h0);
        wait_cycles(8);
        check("stop_hold", bus.TIME, 16'h0003);
        do_pulse(0, 1, 0, 0);
        check("clr_time", bus.TIME, 16'h0000);

        // Build 09:59 and carry into 10:00.
        do_pulse(0, 0, 1, 0);
        check("add_0200", bus.TIME, 16'h0200);
        bus.MODE = 1'b1;
        do_pulse(1, 0, 0, 0);
        wait_cycles(4);
        check("down_borrow", bus.TIME, 16'h0159);
        do_pulse(1, 0, 0, 0);
        repeat (4) do_pulse(0, 0, 1, 0);
        check("add_to_0959", bus.TIME, 16'h0959);
        bus.MODE = 1'b0;
        do_pulse(1, 0, 0, 0);
        wait_cycles(4);
        check("carry_1000", bus.TIME, 16'h1000);
        do_pulse(1, 0, 0, 0);

        // Down count to 00:00 reaches DONE and holds.
        do_pulse(0, 1, 0, 0);
        do_pulse(1, 0, 0, 0);
        wait_cycles(4);
        do_pulse(1, 0, 0, 0);
        check("setup_0001", bus.TIME, 16'h0001);
        bus.MODE = 1'b1;
        do_pulse(1, 0, 0, 0);
        wait_cycles(4);
        check("down_zero", bus.TIME, 16'h0000);
        check("down_done", 16'(bus.DONE), 16'h1);
        check("down_not_running", 16'(bus.RUNNING), 16'h0);
        wait_cycles(20);
        check("done_hold_time", bus.TIME, 16'h0000);
        check("done_hold_done", 16'(bus.DONE), 16'h1);
        do_pulse(1, 0, 0, 0);
        check("done_to_idle", 16'(bus.DONE), 16'h0);
        do_pulse(1, 0, 0, 0);
        check("start_blocked_zero", 16'(bus.RUNNING), 16'h0);

        // 58:30, refused ADD2, then up count to the 59:59 limit.
        bus.MODE = 1'b0;
        repeat (29) do_pulse(0, 0, 1, 0);
        check("add_to_5800", bus.TIME, 16'h5800);
        do_pulse(1, 0, 0, 0);
        wait_cycles(120);
        do_pulse(1, 0, 0, 0);
        check("setup_5830", bus.TIME, 16'h5830);
        do_pulse(0, 0, 1, 0);
        check("add_reject_pulse", 16'(bus.REJECT), 16'h1);
        check("add_reject_time", bus.TIME, 16'h5830);
        wait_cycles(1);
        check("add_reject_end", 16'(bus.REJECT), 16'h0);
        do_pulse(1, 0, 0, 0);
        wait_cycles(356);
        check("up_limit_time", bus.TIME, 16'h5959);
        check("up_limit_done", 16'(bus.DONE), 16'h1);
        check("up_limit_running", 16'(bus.RUNNING), 16'h0);
        do_pulse(0, 0, 0, 1);
        check("sub_in_done_time", bus.TIME, 16'h5759);
        check("sub_in_done_state", 16'(bus.DONE), 16'h0);
        do_pulse(0, 0, 1, 0);
        check("add_to_max", bus.TIME, 16'h5959);
        check("add_to_max_reject", 16'(bus.REJECT), 16'h0);
        do_pulse(1, 0, 0, 0);
        check("start_blocked_max", 16'(bus.RUNNING), 16'h0);

        // SUB2 accepted at 02:30 and refused at 01:30; ADD2+SUB2 refused.
        do_pulse(0, 1, 0, 0);
        do_pulse(0, 0, 1, 0);
        do_pulse(0, 0, 1, 0);
        bus.MODE = 1'b1;
        do_pulse(1, 0, 0, 0);
        wait_cycles(360);
        do_pulse(1, 0, 0, 0);
        check("setup_0230", bus.TIME, 16'h0230);
        do_pulse(0, 0, 0, 1);
        check("sub_0030", bus.TIME, 16'h0030);
        do_pulse(0, 0, 1, 0);
        do_pulse(1, 0, 0, 0);
        wait_cycles(240);
        do_pulse(1, 0, 0, 0);
        check("setup_0130", bus.TIME, 16'h0130);
        do_pulse(0, 0, 0, 1);
        check("sub_reject_pulse", 16'(bus.REJECT), 16'h1);
        check("sub_reject_time", bus.TIME, 16'h0130);
        do_pulse(0, 0, 1, 1);
        check("both_reject_pulse", 16'(bus.REJECT), 16'h1);
        check("both_reject_time", bus.TIME, 16'h0130);
        wait_cycles(1);
        check("both_reject_end", 16'(bus.REJECT), 16'h0);

        // ADD2 coincident with a tick at 01:05 drops the tick.
        do_pulse(1, 0, 0, 0);
        wait_cycles(100);
        check("setup_0105", bus.TIME, 16'h0105);
        bus.MODE = 1'b0;
        wait_cycles(3);
        do_pulse(0, 0, 1, 0);
        check("add_on_tick", bus.TIME, 16'h0305);
        check("add_on_tick_running", 16'(bus.RUNNING), 16'h1);
        wait_cycles(3);
        check("tick_lost", bus.TIME, 16'h0305);
        wait_cycles(1);
        check("next_tick", bus.TIME, 16'h0306);

        // CLR wins over START_STOP; refused adjustment under CLR still rejects.
        do_pulse(1, 1, 0, 0);
        check("clr_ss_time", bus.TIME, 16'h0000);
        check("clr_ss_running", 16'(bus.RUNNING), 16'h0);
        do_pulse(0, 1, 0, 1);
        check("clr_sub_reject", 16'(bus.REJECT), 16'h1);
        check("clr_sub_time", bus.TIME, 16'h0000);

        // Reset mid-run.
        do_pulse(1, 0, 0, 0);
        wait_cycles(6);
        check("pre_rst_time", bus.TIME, 16'h0001);
        RST = 1'b0;
        wait_cycles(1);
        check("mid_rst_time", bus.TIME, 16'h0000);
        check("mid_rst_running", 16'(bus.RUNNING), 16'h0);
        check("mid_rst_done", 16'(bus.DONE), 16'h0);
        check("mid_rst_reject", 16'(bus.REJECT), 16'h0);
        RST = 1'b1;
        do_pulse(1, 0, 0, 0);
        check("first_event_after_rst", 16'(bus.RUNNING), 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
